// File: rtl/nor_bus_sequencer.sv
// Single-cycle sequencer for an asynchronous NOR flash bus: read, write and ready-wait cycles.
// All pad-facing outputs are registered; pulse widths are counted in sysclk cycles.
module nor_bus_sequencer #(
   parameter int unsigned T_AS    = 2,
   parameter int unsigned T_RD    = 24,
   parameter int unsigned T_WP    = 12,
   parameter int unsigned T_DH    = 3,
   parameter int unsigned T_REC   = 6,
   parameter int unsigned T_BLANK = 48,
   parameter int unsigned TO_W    = 24
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wait_i,
   input  logic        req_we_i,
   input  logic [25:0] req_addr_i,
   input  logic [15:0] req_data_i,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        busy_o,
   output logic [25:0] nor_addr_o,
   output logic [15:0] nor_data_o,
   output logic        nor_data_oe_o,
   input  logic [15:0] nor_data_i,
   output logic        nor_ce_o,
   output logic        nor_oe_o,
   output logic        nor_we_o,
   input  logic        nor_ry_i
);

   // A zero timing parameter still yields a one-cycle phase.
   localparam int unsigned TAs    = (T_AS    == 0) ? 1 : T_AS;
   localparam int unsigned TRd    = (T_RD    == 0) ? 1 : T_RD;
   localparam int unsigned TWp    = (T_WP    == 0) ? 1 : T_WP;
   localparam int unsigned TDh    = (T_DH    == 0) ? 1 : T_DH;
   localparam int unsigned TRec   = (T_REC   == 0) ? 1 : T_REC;
   localparam int unsigned TBlank = (T_BLANK == 0) ? 1 : T_BLANK;

   localparam logic [15:0] LdAs    = 16'(TAs - 1);
   localparam logic [15:0] LdRd    = 16'(TRd - 1);
   localparam logic [15:0] LdWp    = 16'(TWp - 1);
   localparam logic [15:0] LdDh    = 16'(TDh - 1);
   localparam logic [15:0] LdRec   = 16'(TRec - 1);
   localparam logic [15:0] LdBlank = 16'(TBlank - 1);

   typedef enum logic [2:0] {
      StIdle, StSetup, StRead, StWrite, StHold, StRecover, StBlank, StWaitRy
   } state_e;

   state_e            state_q;
   logic [15:0]       cnt_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              is_we_q;
   logic [1:0]        ry_sync_q;

   assign req_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ry_sync_q <= 2'b11;
      end else begin
         ry_sync_q <= {ry_sync_q[0], nor_ry_i};
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         to_cnt_q      <= '0;
         is_we_q       <= 1'b0;
         nor_ce_o      <= 1'b1;
         nor_oe_o      <= 1'b1;
         nor_we_o      <= 1'b1;
         nor_data_oe_o <= 1'b0;
         nor_addr_o    <= '0;
         nor_data_o    <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_data_o    <= '0;
         rsp_err_o     <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  if (req_wait_i) begin
                     state_q <= StBlank;
                     cnt_q   <= LdBlank;
                  end else begin
                     state_q    <= StSetup;
                     cnt_q      <= LdAs;
                     is_we_q    <= req_we_i;
                     nor_ce_o   <= 1'b0;
                     nor_addr_o <= req_addr_i;
                     if (req_we_i) begin
                        nor_data_oe_o <= 1'b1;
                        nor_data_o    <= req_data_i;
                     end
                  end
               end
            end
            StSetup: begin
               if (cnt_q == '0) begin
                  if (is_we_q) begin
                     state_q  <= StWrite;
                     cnt_q    <= LdWp;
                     nor_we_o <= 1'b0;
                  end else begin
                     state_q  <= StRead;
                     cnt_q    <= LdRd;
                     nor_oe_o <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            StRead: begin
               if (cnt_q == '0) begin
                  // DQ is captured in the last OE# low cycle, before OE# rises.
                  rsp_data_o <= nor_data_i;
                  nor_oe_o   <= 1'b1;
                  state_q    <= StHold;
                  cnt_q      <= LdDh;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            StWrite: begin
               if (cnt_q == '0) begin
                  nor_we_o <= 1'b1;
                  state_q  <= StHold;
                  cnt_q    <= LdDh;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            StHold: begin
               if (cnt_q == '0) begin
                  nor_ce_o      <= 1'b1;
                  nor_data_oe_o <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b0;
                  state_q       <= StRecover;
                  cnt_q         <= LdRec;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            StRecover: begin
               if (cnt_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            StBlank: begin
               if (cnt_q == '0) begin
                  state_q  <= StWaitRy;
                  to_cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            StWaitRy: begin
               // Ready is checked before timeout so a coincident ready reports success.
               if (ry_sync_q[1]) begin
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  state_q     <= StIdle;
               end else if (to_cnt_q == '1) begin
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_nor_bus_sequencer.sv
// Randomised bench for nor_bus_sequencer; expected bus timing is derived from the phase widths.
module tb_nor_bus_sequencer;

   localparam int T_AS    = 2;
   localparam int T_RD    = 24;
   localparam int T_WP    = 12;
   localparam int T_DH    = 3;
   localparam int T_REC   = 6;
   localparam int T_BLANK = 48;
   localparam int TO_W    = 8;
   localparam int TO_MAX  = (1 << TO_W) - 1;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_wait_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [25:0] req_addr_i = '0;
   logic [15:0] req_data_i = '0;
   logic        rsp_valid_o;
   logic [15:0] rsp_data_o;
   logic        rsp_err_o;
   logic        busy_o;
   logic [25:0] nor_addr_o;
   logic [15:0] nor_data_o;
   logic        nor_data_oe_o;
   logic [15:0] nor_data_i;
   logic        nor_ce_o;
   logic        nor_oe_o;
   logic        nor_we_o;
   logic        nor_ry_i = 1'b1;

   logic [15:0] dq_val = 16'hBEEF;
   logic [15:0] last_rd = 16'h0000;
   int          n_checks = 0;
   int          n_fail = 0;

   // The flash only presents the true word while OE# is low.
   assign nor_data_i = nor_oe_o ? ~dq_val : dq_val;

   always #5 clk_i = ~clk_i;

   nor_bus_sequencer #(
      .T_AS(T_AS), .T_RD(T_RD), .T_WP(T_WP), .T_DH(T_DH),
      .T_REC(T_REC), .T_BLANK(T_BLANK), .TO_W(TO_W)
   ) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_wait_i(req_wait_i), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .busy_o(busy_o),
      .nor_addr_o(nor_addr_o), .nor_data_o(nor_data_o), .nor_data_oe_o(nor_data_oe_o),
      .nor_data_i(nor_data_i),
      .nor_ce_o(nor_ce_o), .nor_oe_o(nor_oe_o), .nor_we_o(nor_we_o),
      .nor_ry_i(nor_ry_i)
   );

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // op: 0 read, 1 write, 2 ready-wait; ry_rise < 0 keeps RY/BY# low (timeout).
   task automatic run_op(input int op, input logic [25:0] addr, input logic [15:0] data,
                         input int ry_rise);
      int oe_first = -1, oe_cnt = 0, we_first = -1, we_cnt = 0, ce_cnt = 0, overlap = 0;
      int doe_first = -1, doe_last = -1, doe_bad = 0, addr_bad = 0;
      int rsp_cyc = -1, rsp_cnt = 0, rdy_cyc = -1, lo, hi, exp_rsp;
      logic        r_err = 1'b0;
      logic [15:0] r_dat = '0;
      @(negedge clk_i);
      check_eq("ready_before_req", req_ready_o, 1);
      nor_ry_i    = (op == 2) ? 1'b0 : 1'b1;
      req_valid_i = 1'b1;
      req_wait_i  = (op == 2);
      req_we_i    = (op == 1) || (op == 2 && $urandom_range(0, 1) == 1);
      req_addr_i  = addr;
      req_data_i  = data;
      for (int c = 1; c <= 600; c++) begin
         @(posedge clk_i);
         #1;
         if (c == 1) begin
            req_valid_i = 1'b0;
            req_addr_i  = 26'($urandom);
            req_data_i  = 16'($urandom);
         end
         if (c == ry_rise) nor_ry_i = 1'b1;
         @(negedge clk_i);
         if (!nor_ce_o) begin
            ce_cnt++;
            if (nor_addr_o !== addr) addr_bad++;
         end
         if (!nor_oe_o) begin
            if (oe_first < 0) oe_first = c;
            oe_cnt++;
         end
         if (!nor_we_o) begin
            if (we_first < 0) we_first = c;
            we_cnt++;
         end
         if (!nor_oe_o && (!nor_we_o || nor_data_oe_o)) overlap++;
         if (nor_data_oe_o) begin
            if (doe_first < 0) doe_first = c;
            doe_last = c;
            if (nor_data_o !== data) doe_bad++;
         end
         if (rsp_valid_o) begin
            rsp_cnt++;
            rsp_cyc = c;
            r_err   = rsp_err_o;
            r_dat   = rsp_data_o;
         end
         if (req_ready_o && rsp_cnt > 0) begin
            rdy_cyc = c;
            break;
         end
      end
      check_eq("rsp_count", rsp_cnt, 1);
      check_eq("bus_overlap", overlap, 0);
      if (op != 2) begin
         exp_rsp = 1 + T_AS + ((op == 0) ? T_RD : T_WP) + T_DH;
         check_eq("rsp_cycle", rsp_cyc, exp_rsp);
         check_eq("ready_cycle", rdy_cyc, exp_rsp + T_REC);
         check_eq("rsp_err_rw", r_err, 0);
         check_eq("ce_low_cycles", ce_cnt, exp_rsp - 1);
         check_eq("addr_while_ce", addr_bad, 0);
         check_eq("addr_held", nor_addr_o, addr);
         if (op == 0) begin
            check_eq("oe_first", oe_first, 1 + T_AS);
            check_eq("oe_width", oe_cnt, T_RD);
            check_eq("we_on_read", we_cnt, 0);
            check_eq("dq_driven_on_read", doe_first, -1);
            check_eq("read_data", r_dat, dq_val);
            last_rd = dq_val;
         end else begin
            check_eq("we_first", we_first, 1 + T_AS);
            check_eq("we_width", we_cnt, T_WP);
            check_eq("oe_on_write", oe_cnt, 0);
            check_eq("dq_first", doe_first, 1);
            check_eq("dq_last", doe_last, T_AS + T_WP + T_DH);
            check_eq("dq_value", doe_bad, 0);
            check_eq("rsp_data_held", r_dat, last_rd);
         end
      end else begin
         check_eq("wait_bus_idle", ce_cnt + oe_cnt + we_cnt + (doe_first + 1), 0);
         check_eq("rsp_data_held_wait", r_dat, last_rd);
         if (ry_rise >= 0) begin
            lo = ry_rise + 2;
            hi = ry_rise + 4;
         end else begin
            lo = T_BLANK + TO_MAX;
            hi = T_BLANK + TO_MAX + 2;
         end
         check_eq($sformatf("wait_rsp_cycle=%0d in [%0d,%0d]", rsp_cyc, lo, hi),
                  (rsp_cyc >= lo && rsp_cyc <= hi), 1);
         check_eq("wait_err", r_err, (ry_rise < 0));
      end
      nor_ry_i = 1'b1;
   endtask

   initial begin
      int acc, pulses, ce_hi, min_gap, done_cyc;
      logic seen_low;
      int op, rise;

      // Reset state, sampled both in and after reset.
      repeat (3) @(negedge clk_i);
      check_eq("rst_ce", nor_ce_o, 1);
      reset_ni = 1'b1;
      repeat (4) @(negedge clk_i);
      check_eq("idle_strobes", {nor_ce_o, nor_oe_o, nor_we_o}, 3'b111);
      check_eq("idle_dq_oe", nor_data_oe_o, 0);
      check_eq("idle_ready", req_ready_o, 1);
      check_eq("idle_busy", busy_o, 0);
      check_eq("idle_addr", nor_addr_o, 0);
      check_eq("idle_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, 0);

      dq_val = 16'hBEEF;
      run_op(0, 26'h155_AAAA, 16'h0000, -1);
      run_op(1, 26'h000_0555, 16'h00AA, -1);
      run_op(2, 26'h0, 16'h0, 200);
      run_op(2, 26'h0, 16'h0, -1);
      dq_val = 16'h1234;
      run_op(0, 26'h3FF_FFFF, 16'h0, -1);

      for (int i = 0; i < 14; i++) begin
         op     = $urandom_range(0, 2);
         dq_val = 16'($urandom);
         rise   = T_BLANK + 2 + $urandom_range(0, 100);
         run_op(op, 26'($urandom), 16'($urandom), rise);
      end

      // Valid held high across three reads.
      dq_val = 16'h5A5A;
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_wait_i  = 1'b0;
      req_we_i    = 1'b0;
      req_addr_i  = 26'h0AB_CDEF;
      acc = 0; pulses = 0; ce_hi = 0; min_gap = 9999; seen_low = 1'b0; done_cyc = -1;
      for (int c = 0; c < 300; c++) begin
         if (req_valid_i && req_ready_o) acc++;
         @(posedge clk_i);
         #1;
         if (acc == 3) req_valid_i = 1'b0;
         @(negedge clk_i);
         if (rsp_valid_o) pulses++;
         if (nor_ce_o) begin
            ce_hi++;
         end else begin
            if (seen_low && ce_hi > 0 && ce_hi < min_gap) min_gap = ce_hi;
            ce_hi    = 0;
            seen_low = 1'b1;
         end
         if (pulses == 3 && req_ready_o && !req_valid_i) begin
            done_cyc = c;
            break;
         end
      end
      check_eq("b2b_done", (done_cyc >= 0), 1);
      check_eq("b2b_accepts", acc, 3);
      check_eq("b2b_pulses", pulses, 3);
      check_eq($sformatf("b2b_ce_gap=%0d min %0d", min_gap, T_REC), (min_gap >= T_REC), 1);
      check_eq("b2b_data", rsp_data_o, 16'h5A5A);

      // Reset asserted in the middle of a write.
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_wait_i  = 1'b0;
      req_we_i    = 1'b1;
      req_addr_i  = 26'h123_4567;
      req_data_i  = 16'hC0DE;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      repeat (7) @(negedge clk_i);
      check_eq("abort_we_low", {nor_we_o, nor_data_oe_o}, 2'b01);
      #1;
      reset_ni = 1'b0;
      #1;
      check_eq("abort_strobes", {nor_ce_o, nor_oe_o, nor_we_o}, 3'b111);
      check_eq("abort_dq_released", nor_data_oe_o, 0);
      check_eq("abort_ready", req_ready_o, 1);
      repeat (3) @(negedge clk_i);
      reset_ni = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_i);
         if (rsp_valid_o) pulses++;
      end
      check_eq("abort_no_rsp", pulses, 0);
      check_eq("abort_busy", busy_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nor_bus_sequencer.md
Name: nor_bus_sequencer

Overview:
- Sequences single asynchronous NOR flash bus cycles (read, write, ready-wait) on the 26-bit address / 16-bit DQ interface.
- Receives one request at a time on a valid/ready request port and returns one response pulse per request.
- Sits between the command decoder and the NOR pads.
- Owns CE#/OE#/WE#, address, DQ direction and RY/BY# polling; all pulse widths are counted in sysclk cycles (240 MHz).

Parameters:
- T_AS, 2, address/CE setup cycles before OE# or WE# falls (0 treated as 1)
- T_RD, 24, OE# low cycles; DQ sampled in the last of them (0 treated as 1)
- T_WP, 12, WE# low cycles (0 treated as 1)
- T_DH, 3, cycles address/data/CE# held after OE#/WE# rises (0 treated as 1)
- T_REC, 6, CE# high recovery cycles before next request accepted (0 treated as 1)
- T_BLANK, 48, cycles after a wait request before RY/BY# is sampled (0 treated as 1)
- TO_W, 24, width of ready-wait timeout counter; timeout = 2^TO_W-1 cycles

Ports:
- clk_i  in  1  sysclk
- reset_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_wait_i  in  1  ready-wait request; takes precedence over req_we_i
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  26  word address
- req_data_i  in  16  write data
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_data_o  out  16  read data; holds last value
- rsp_err_o  out  1  ready-wait timeout; qualified by rsp_valid_o
- busy_o  out  1  high whenever not IDLE
- nor_addr_o  out  26  NOR address
- nor_data_o  out  16  NOR write data
- nor_data_oe_o  out  1  DQ output enable
- nor_data_i  in  16  NOR read data
- nor_ce_o, nor_oe_o, nor_we_o  out  1 each  active-low strobes
- nor_ry_i  in  1  RY/BY#, asynchronous

Behaviour:
- Clock and reset: one clock, clk_i; reset_ni is asynchronous and active-low.
- Reset values:
  - nor_ce_o=1, nor_oe_o=1, nor_we_o=1
  - nor_data_oe_o=0, nor_addr_o=0, nor_data_o=0
  - rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0
  - busy_o=0, req_ready_o=1
  - state=IDLE, counters=0, ry synchroniser=2'b11
- Reset mid-cycle: all strobes return high and DQ is released immediately. No response is issued for the aborted request.
- Outputs: all are registered (no combinational paths to pads). req_ready_o and busy_o are decoded from state.
- Sequencing: a down-counter is loaded with N-1 on state entry; the state is left when the counter reaches 0.
- Acceptance: a request is taken in the cycle where req_valid_i and req_ready_o are both high. Its op, address and data are latched. nor_addr_o keeps its value after the cycle ends.
- States:
  - IDLE: on accept, go to SETUP for read/write, or BLANK for wait.
  - SETUP (T_AS): CE#=0, address driven. Write also sets nor_data_oe_o=1 with nor_data_o=data. Next state is READ or WRITE.
  - READ (T_RD): OE#=0. In the last cycle, rsp_data_o <= nor_data_i. Next state is HOLD.
  - WRITE (T_WP): WE#=0. Next state is HOLD.
  - HOLD (T_DH): OE#=WE#=1; CE#, address and data stay driven. On exit, CE#=1, nor_data_oe_o=0, rsp_valid_o=1 for 1 cycle, rsp_err_o=0. Next state is RECOVER.
  - RECOVER (T_REC): CE#=1. Next state is IDLE.
  - BLANK (T_BLANK): strobes idle. Next state is WAITRY.
  - WAITRY: poll the 2-FF synchronised nor_ry_i.
    - ry=1: rsp_valid_o=1, rsp_err_o=0, go to IDLE.
    - Timeout counter reaches all-ones first: rsp_valid_o=1, rsp_err_o=1, go to IDLE.
    - ry=1 in the same cycle as timeout: success wins.
- Latency from accept cycle (cycle 0) to next req_ready_o:
  - Read/write: 1+T_AS+T_RD(or T_WP)+T_DH+T_REC cycles.
  - rsp_valid_o fires in the first RECOVER cycle.
- Write data: DQ is never driven while OE#=0. nor_data_oe_o rises with CE# falling and falls with CE# rising.
- Input stability: req_* inputs are ignored outside IDLE. A valid held high is accepted again only when the sequencer is back in IDLE.

Test Plan:
- Reset and idle: reset_ni=0 then 1, no request → CE#/OE#/WE#=1, nor_data_oe_o=0, req_ready_o=1, busy_o=0.
- Read, defaults: addr=26'h155_AAAA, DQ model drives 16'hBEEF only while OE# is low.
  - OE# low for exactly 24 cycles, starting 3 cycles after accept.
  - rsp_valid_o at cycle 30 with rsp_data_o=16'hBEEF; req_ready_o back at cycle 36.
- Write: addr=26'h000_0555, data=16'h00AA.
  - WE# low for exactly 12 cycles, never overlapping OE#=0.
  - DQ driven with 16'h00AA from cycle 1 to cycle 17.
  - rsp_valid_o at cycle 18, rsp_err_o=0.
- Ready-wait, success: RY/BY# low at request, high at cycle 200 → rsp_valid_o at cycle 203±1, rsp_err_o=0.
- Ready-wait, timeout with TO_W=8: RY/BY# held low → rsp_valid_o with rsp_err_o=1 after T_BLANK+255 cycles; a following read completes normally.
- Back-to-back and reset abort:
  - Valid held high for 3 reads → three rsp pulses, CE# high ≥6 cycles between each.
  - reset_ni pulled low mid-WRITE → all strobes high and DQ released at once, no rsp_valid_o.
